alu16_sequencer: RTL and testbench
==================================

Name: alu16_sequencer

Overview:
- Upstream companion to the 8-bit ALU. Runs 16-bit arithmetic (ADD HL,rr / ADD SP,e / INC rr / DEC rr) as two ALU byte passes: low byte first, then high byte.
- Drives the ALU operand and carry-in lines, and chains the low-byte carry into the high byte.
- Collects the 16-bit result and the H/C/N/Z flag updates.
- Hands the result to register-file writeback with a one-cycle done strobe.

Parameters:
- LAT_LO, 1, cycles the state machine stays in the LO pass (fixed; present for timing experiments only; values other than 1 are unsupported).

Ports:
- CLK  in  1  single system clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  request a 16-bit op; sampled only in IDLE.
- op_sel  in  2  0=ADD16, 1=ADD_SP_E, 2=INC16, 3=DEC16.
- opa  in  16  operand 1 (HL, SP or rr).
- opb  in  16  operand 2 (rr for ADD16; [7:0]=e for ADD_SP_E; ignored for INC/DEC).
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle strobe; result and flags are valid.
- result  out  16  16-bit result; held until the next accepted start.
- flags_out  out  4  {Z,N,H,C}.
- flags_we  out  4  per-flag write enables, same order, qualified by done.
- alu_a  out  8  ALU operand 1 byte.
- alu_b  out  8  ALU operand 2 byte.
- alu_cin  out  1  ALU carry-in.
- alu_req  out  1  ALU pass active (sum mode) this cycle.
- alu_res  in  8  ALU sum, combinational same cycle.
- alu_cout  in  1  ALU carry out of bit 7.
- alu_hcout  in  1  ALU carry out of bit 3.

Behaviour:
- Reset: state=IDLE. busy=0, done=0, result=0, flags_out=0, flags_we=0, alu_a=0, alu_b=0, alu_cin=0, alu_req=0. Reset takes effect mid-operation; the partial result is discarded and done is not emitted.
- States: IDLE -> LO -> HI -> DONE -> IDLE.
- IDLE: when start=1, latch op_sel/opa/opb and go to LO. Outputs unchanged.
- LO: alu_req=1, alu_a=opa[7:0], alu_cin=0. alu_b by op:
  - ADD16: opb[7:0].
  - ADD_SP_E: e.
  - INC16: 0x01.
  - DEC16: 0xFF.
  - At the clock edge, register lo_res=alu_res, lo_c=alu_cout, lo_h=alu_hcout.
- HI: alu_req=1, alu_a=opa[15:8], alu_cin=lo_c. alu_b by op:
  - ADD16: opb[15:8].
  - ADD_SP_E: {8{e[7]}}.
  - INC16: 0x00.
  - DEC16: 0xFF.
  - At the clock edge, register result={alu_res, lo_res}, hi_c=alu_cout, hi_h=alu_hcout.
- DONE: done=1 for one cycle, busy drops to 0 in the same cycle, then return to IDLE.
- start is ignored outside IDLE; no queueing. A start in the DONE cycle is lost.
- Total latency: start accepted at edge N; done high in cycle N+3.
- Flags:
  - ADD16: N=0, H=hi_h (bit 11), C=hi_c (bit 15). flags_we={0,1,1,1}; Z is preserved.
  - ADD_SP_E: Z=0, N=0, H=lo_h, C=lo_c. flags_we=4'b1111.
  - INC16/DEC16: flags_we=0, flags_out=0.
- flags_we is 0 in every cycle except DONE.
- alu_req=0 and alu_a/alu_b/alu_cin=0 outside LO/HI.
- Arithmetic wraps modulo 2^16: 0xFFFF+1=0x0000; 0x0000-1=0xFFFF.

Optional Feature:
- SEQ_INCDEC_BYPASS_EN
- Defined:
  - INC16/DEC16 skip the ALU and use an internal 16-bit incrementer/decrementer.
  - Path is IDLE -> DONE; done arrives in cycle N+1.
  - alu_req stays 0 for these ops.
  - ADD16 and ADD_SP_E are unchanged.
- Undefined:
  - All ops take the two-pass path described under Behaviour.
  - No incrementer logic is instantiated.

Decomposition:
- Shared package alu16_seq_pkg:
  - op_sel encodings: OP_ADD16, OP_ADD_SP_E, OP_INC16, OP_DEC16.
  - State enum: IDLE, LO, HI, DONE.
  - Flag index constants: FZ=3, FN=2, FH=1, FC=0.
- One natural sub-module, seq_operand_mux: combinational selection of alu_b and alu_cin from op, state and lo_c.
- FSM and registers stay in the top module.

Test Plan:
- ADD16, opa=0x0FFF, opb=0x0001 -> done at N+3; result=0x1000; flags_out N=0,H=1,C=0; flags_we=4'b0111.
- ADD_SP_E, opa=0xFFF8, e=0x08 -> LO pass alu_b=0x08; HI pass alu_b=0x00, alu_cin=1; result=0x0000; Z=0,N=0,H=1,C=1; flags_we=4'b1111.
- ADD_SP_E, opa=0x0000, e=0xFF -> HI pass alu_b=0xFF; result=0xFFFF; H=0,C=0.
- DEC16, opa=0x0100 -> result=0x00FF; flags_we=0.
- INC16, opa=0xFFFF -> result=0x0000 (with SEQ_INCDEC_BYPASS_EN: done at N+1, alu_req never high).
- Reset during HI of ADD16 -> next cycle: IDLE, busy=0, result=0, no done.
- start pulsed during LO and HI -> ignored; exactly one done; result from the first operands.

Source files
------------

// File: rtl/alu16_seq_pkg.sv
// Shared encodings for the 16-bit ALU sequencer: op codes, FSM states, flag bit positions.
// Flag vectors are ordered {Z,N,H,C}.
package alu16_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD16    = 2'd0,
        OP_ADD_SP_E = 2'd1,
        OP_INC16    = 2'd2,
        OP_DEC16    = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int FZ = 3;
    localparam int FN = 2;
    localparam int FH = 1;
    localparam int FC = 0;

    // ADD16 leaves Z untouched; INC16/DEC16 touch no flags at all.
    function automatic logic [3:0] flag_we_for(input op_e op);
        logic [3:0] we;
        we = 4'b0000;
        case (op)
            OP_ADD16:    we = 4'b0111;
            OP_ADD_SP_E: we = 4'b1111;
            default:     we = 4'b0000;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/alu16_sequencer_operand_mux.sv
// Combinational ALU operand-2 byte and carry-in selection for the LO/HI passes.
// Zero latency; drives zeros outside LO/HI.
module seq_operand_mux
    import alu16_seq_pkg::*;
(
    input  op_e         op,
    input  state_e      state,
    input  logic [15:0] opb,
    input  logic        lo_c,
    output logic [7:0]  alu_b,
    output logic        alu_cin
);

    always_comb begin
        alu_b   = 8'h00;
        alu_cin = 1'b0;
        case (state)
            LO: begin
                case (op)
                    OP_ADD16:    alu_b = opb[7:0];
                    OP_ADD_SP_E: alu_b = opb[7:0];
                    OP_INC16:    alu_b = 8'h01;
                    OP_DEC16:    alu_b = 8'hFF;
                    default:     alu_b = 8'h00;
                endcase
            end
            HI: begin
                alu_cin = lo_c;
                // DEC16 is opa + 0xFFFF, so the high byte adds 0xFF plus the low carry.
                case (op)
                    OP_ADD16:    alu_b = opb[15:8];
                    OP_ADD_SP_E: alu_b = {8{opb[7]}};
                    OP_INC16:    alu_b = 8'h00;
                    OP_DEC16:    alu_b = 8'hFF;
                    default:     alu_b = 8'h00;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu16_sequencer.sv
// 16-bit ADD/ADD SP,e/INC/DEC as two 8-bit ALU passes; done in cycle N+3 after start at edge N, no queueing.
// SEQ_INCDEC_BYPASS_EN: INC16/DEC16 use an internal incrementer and finish in cycle N+1.
module alu16_sequencer
    import alu16_seq_pkg::*;
#(
    parameter int LAT_LO = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [1:0]  op_sel,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [3:0]  flags_out,
    output logic [3:0]  flags_we,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_req,
    input  logic [7:0]  alu_res,
    input  logic        alu_cout,
    input  logic        alu_hcout
);

    localparam logic [7:0] LO_LAST = 8'(LAT_LO - 1);

    state_e      state_q,  state_d;
    op_e         op_q,     op_d;
    logic [15:0] opa_q,    opa_d;
    logic [15:0] opb_q,    opb_d;
    logic [7:0]  lo_res_q, lo_res_d;
    logic        lo_c_q,   lo_c_d;
    logic        lo_h_q,   lo_h_d;
    logic [7:0]  lo_cnt_q, lo_cnt_d;
    logic [15:0] result_q, result_d;
    logic [3:0]  flags_q,  flags_d;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        lo_res_d = lo_res_q;
        lo_c_d   = lo_c_q;
        lo_h_d   = lo_h_q;
        lo_cnt_d = lo_cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op_e'(op_sel);
                    opa_d    = opa;
                    opb_d    = opb;
                    lo_cnt_d = 8'h00;
                    state_d  = LO;
`ifdef SEQ_INCDEC_BYPASS_EN
                    if (op_e'(op_sel) == OP_INC16) begin
                        result_d = opa + 16'd1;
                        flags_d  = 4'b0000;
                        state_d  = DONE;
                    end else if (op_e'(op_sel) == OP_DEC16) begin
                        result_d = opa - 16'd1;
                        flags_d  = 4'b0000;
                        state_d  = DONE;
                    end
`endif
                end
            end
            LO: begin
                lo_res_d = alu_res;
                lo_c_d   = alu_cout;
                lo_h_d   = alu_hcout;
                lo_cnt_d = lo_cnt_q + 8'd1;
                if (lo_cnt_q == LO_LAST) begin
                    state_d = HI;
                end
            end
            HI: begin
                result_d = {alu_res, lo_res_q};
                flags_d  = 4'b0000;
                // ADD16 reports the high-pass carries (bits 11/15); ADD SP,e the low-pass ones (bits 3/7).
                case (op_q)
                    OP_ADD16: begin
                        flags_d[FH] = alu_hcout;
                        flags_d[FC] = alu_cout;
                    end
                    OP_ADD_SP_E: begin
                        flags_d[FH] = lo_h_q;
                        flags_d[FC] = lo_c_q;
                    end
                    default: flags_d = 4'b0000;
                endcase
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD16;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            lo_res_q <= 8'h00;
            lo_c_q   <= 1'b0;
            lo_h_q   <= 1'b0;
            lo_cnt_q <= 8'h00;
            result_q <= 16'h0000;
            flags_q  <= 4'b0000;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            lo_res_q <= lo_res_d;
            lo_c_q   <= lo_c_d;
            lo_h_q   <= lo_h_d;
            lo_cnt_q <= lo_cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    seq_operand_mux u_operand_mux (
        .op      (op_q),
        .state   (state_q),
        .opb     (opb_q),
        .lo_c    (lo_c_q),
        .alu_b   (alu_b),
        .alu_cin (alu_cin)
    );

    always_comb begin
        busy      = (state_q == LO) || (state_q == HI);
        alu_req   = busy;
        done      = (state_q == DONE);
        result    = result_q;
        flags_out = flags_q;
        flags_we  = done ? flag_we_for(op_q) : 4'b0000;
        alu_a     = 8'h00;
        if (state_q == LO) begin
            alu_a = opa_q[7:0];
        end else if (state_q == HI) begin
            alu_a = opa_q[15:8];
        end
    end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Scoreboard bench for alu16_sequencer with a behavioural 8-bit ALU; aware of SEQ_INCDEC_BYPASS_EN.
module tb_alu16_sequencer;

`ifdef SEQ_INCDEC_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK, RESET, start;
    logic [1:0]  op_sel;
    logic [15:0] opa, opb;
    logic        busy, done, alu_cin, alu_req;
    logic [15:0] result;
    logic [3:0]  flags_out, flags_we;
    logic [7:0]  alu_a, alu_b, alu_res;
    logic        alu_cout, alu_hcout;

    alu16_sequencer #(.LAT_LO(1)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .op_sel(op_sel),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result),
        .flags_out(flags_out), .flags_we(flags_we), .alu_a(alu_a),
        .alu_b(alu_b), .alu_cin(alu_cin), .alu_req(alu_req),
        .alu_res(alu_res), .alu_cout(alu_cout), .alu_hcout(alu_hcout)
    );

    logic [8:0] sum9;
    logic [4:0] sum5;
    assign sum9      = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
    assign sum5      = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'h0, alu_cin};
    assign alu_res   = sum9[7:0];
    assign alu_cout  = sum9[8];
    assign alu_hcout = sum5[4];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  flg;
        logic [3:0]  we;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic        cin1;
        int          npass;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   done_cnt = 0;
    int   pass_cnt = 0;
    logic [7:0] seen_b [2];
    logic       seen_cin1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        logic [16:0] s;
        logic [12:0] h12;
        logic [8:0]  s8;
        logic [4:0]  s4;
        logic [7:0]  ev;
        e = '{default: 0};
        ev = b[7:0];
        case (op)
            2'd0: begin
                s   = {1'b0, a} + {1'b0, b};
                h12 = {1'b0, a[11:0]} + {1'b0, b[11:0]};
                e.res = s[15:0];
                e.flg = {2'b00, h12[12], s[16]};
                e.we  = 4'b0111;
                e.b0  = b[7:0];
                e.b1  = b[15:8];
            end
            2'd1: begin
                s8 = {1'b0, a[7:0]} + {1'b0, ev};
                s4 = {1'b0, a[3:0]} + {1'b0, ev[3:0]};
                e.res = a + {{8{ev[7]}}, ev};
                e.flg = {2'b00, s4[4], s8[8]};
                e.we  = 4'b1111;
                e.b0  = ev;
                e.b1  = {8{ev[7]}};
            end
            2'd2: begin
                e.res = a + 16'd1;
                e.b0  = 8'h01;
                e.b1  = 8'h00;
            end
            default: begin
                e.res = a - 16'd1;
                e.b0  = 8'hFF;
                e.b1  = 8'hFF;
            end
        endcase
        s8 = {1'b0, a[7:0]} + {1'b0, e.b0};
        e.cin1  = s8[8];
        e.npass = 2;
        e.lat   = 3;
        if (BYP && op[1]) begin
            e.npass = 0;
            e.lat   = 1;
        end
        return e;
    endfunction

    // Monitor: records ALU passes and scores every done against the queue head.
    always @(negedge CLK) begin
        if (RESET) begin
            pass_cnt = 0;
        end else begin
            if (alu_req) begin
                if (pass_cnt < 2) seen_b[pass_cnt] = alu_b;
                if (pass_cnt == 1) seen_cin1 = alu_cin;
                pass_cnt++;
            end
            if (!done && flags_we != 4'b0000) check("flags_we_outside_done", flags_we, 0);
            if (done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("flags_out", flags_out, e.flg);
                    check("flags_we", flags_we, e.we);
                    check("busy_at_done", busy, 0);
                    check("latency", int'(($time - e.t_acc - 5) / 10) + 1, e.lat);
                    check("alu_passes", pass_cnt, e.npass);
                    if (e.npass == 2) begin
                        check("lo_alu_b", seen_b[0], e.b0);
                        check("hi_alu_b", seen_b[1], e.b1);
                        check("hi_alu_cin", seen_cin1, e.cin1);
                    end
                end
                pass_cnt = 0;
            end
        end
    end

    // hold: extra edges start stays high (with scrambled operands) after acceptance.
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
        exp_t e;
        @(negedge CLK);
        start = 1'b1; op_sel = op; opa = a; opb = b;
        @(posedge CLK);
        e = model(op, a, b);
        e.t_acc = $time;
        sb.push_back(e);
        #1;
        opa = ~a; opb = b ^ 16'h5A5A; op_sel = op ^ 2'b01;
        repeat (hold) @(posedge CLK);
        #1 start = 1'b0;
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge CLK);
        check("done_timeout", sb.size(), 0);
    endtask

    initial begin
        int d0;
        RESET = 1'b1; start = 1'b0; op_sel = 2'd0; opa = 16'h0; opb = 16'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags_out", flags_out, 0);
        check("rst_flags_we", flags_we, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_b", alu_b, 0);
        check("rst_alu_cin", alu_cin, 0);
        check("rst_alu_req", alu_req, 0);
        RESET = 1'b0;

        run_op(2'd0, 16'h0FFF, 16'h0001, 0);
        run_op(2'd1, 16'hFFF8, 16'h0008, 0);
        run_op(2'd1, 16'h0000, 16'h00FF, 0);
        run_op(2'd3, 16'h0000, 16'h1234, 0);
        run_op(2'd2, 16'hFFFF, 16'h0000, 0);
        run_op(2'd3, 16'h0100, 16'h0000, 0);

        // Abort an ADD16 while in HI; previous result 0x00FF must be cleared.
        @(negedge CLK);
        start = 1'b1; op_sel = 2'd0; opa = 16'h1234; opb = 16'h1111;
        @(posedge CLK);
        #1 start = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("hi_before_reset", alu_req, 1);
        d0 = done_cnt;
        RESET = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_result", result, 0);
        check("rst_mid_alu_req", alu_req, 0);
        RESET = 1'b0;
        repeat (5) @(negedge CLK);
        check("rst_mid_no_done", done_cnt - d0, 0);

        // start held through LO, HI and DONE: exactly one completion from the first operands.
        d0 = done_cnt;
        run_op(2'd0, 16'h1234, 16'h4321, 3);
        repeat (6) @(negedge CLK);
        check("held_start_one_done", done_cnt - d0, 1);

        for (int k = 0; k < 16; k++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 0);
        end

        repeat (3) @(negedge CLK);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
